// File: rtl/state_dump_controller_pkg.sv
// Shared definitions for the halt detector and architectural-state dump walker.
// Holds the stream item kind encodings, the walker state enum and the index width helper.
// Ports: none (package).
package state_dump_controller_pkg;

  // dump_kind encodings carried on the output stream
  localparam logic [1:0] DK_MEM = 2'd0;
  localparam logic [1:0] DK_REG = 2'd1;
  localparam logic [1:0] DK_END = 2'd2;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_MEM  = 3'd1,
    ST_REG  = 3'd2,
    ST_END  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Index width wide enough for both the memory and the register walk.
  function automatic int unsigned idx_width(input int unsigned mem_depth,
                                            input int unsigned reg_count);
    int unsigned a;
    int unsigned b;
    a = $clog2(mem_depth);
    b = $clog2(reg_count);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/state_dump_controller_halt_detector.sv
// Halt detector: counts consecutive valid fetches of HALT_WORD and merges the external halt request.
// Latency: combinational halt pulse in the cycle the deciding fetch/request is presented.
// Backpressure: none; counting is frozen to zero whenever en_i is low.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i enables detection (CPU running);
//        instr_rd_i/instr_valid_i fetch bus; halt_req_i external halt; halt_o one-cycle halt pulse.
module state_dump_controller_halt_detector
  import state_dump_controller_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] HALT_WORD    = '0,
  parameter int unsigned       HALT_CONFIRM = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] instr_rd_i,
  input  logic              instr_valid_i,
  input  logic              halt_req_i,
  output logic              halt_o
);

  localparam int unsigned CNT_W = $clog2(HALT_CONFIRM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_CONFIRM - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  assign hit = instr_valid_i && (instr_rd_i == HALT_WORD);

  // Fires on the fetch that brings the run of halt words up to HALT_CONFIRM,
  // so the counter itself never needs to hold HALT_CONFIRM.
  assign halt_o = en_i && (halt_req_i || (hit && (cnt_q == CNT_LAST)));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || halt_o) begin
      cnt_d = '0;
    end else if (instr_valid_i) begin
      // any other valid word breaks the run; invalid cycles leave it alone
      cnt_d = hit ? (cnt_q + CNT_W'(1)) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/state_dump_controller.sv
// Halt detection and architectural-state streamer: after halt, stalls the CPU and streams memory, registers, then a cycle-count end marker.
// Latency: cpu_stall rises the edge halt is sampled; first item valid one edge later; one item per cycle when unthrottled.
// Backpressure: valid/ready; while dump_valid && !dump_ready the item and the walk addresses hold.
// Ports: clk/rst_n; instr_rd/instr_valid fetch bus; halt_req external halt; cpu_stall CPU freeze;
//        mem_a/mem_rd and reg_a/reg_rd combinational read ports; dump_* output stream; done sticky completion.
module state_dump_controller
  import state_dump_controller_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       MEM_DEPTH    = 64,
  parameter int unsigned       REG_COUNT    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD    = '0,
  parameter int unsigned       HALT_CONFIRM = 1,
  parameter int unsigned       CYC_W        = 32,
  localparam int unsigned      IDX_W        = idx_width(MEM_DEPTH, REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr_rd,
  input  logic              instr_valid,
  input  logic              halt_req,
  output logic              cpu_stall,
  output logic [IDX_W-1:0]  mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [IDX_W-1:0]  reg_a,
  input  logic [DATA_W-1:0] reg_rd,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [1:0]        dump_kind,
  output logic [IDX_W-1:0]  dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              done
);

  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = '1;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CYC_W-1:0]  cyc_q;
  logic              valid_q;
  logic [1:0]        kind_q;
  logic [IDX_W-1:0]  index_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;

  logic              run_st;
  logic              halt;
  logic              load_d;

  assign run_st = (state_q == ST_RUN);

  state_dump_controller_halt_detector #(
    .DATA_W       (DATA_W),
    .HALT_WORD    (HALT_WORD),
    .HALT_CONFIRM (HALT_CONFIRM)
  ) u_halt_detector (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (run_st),
    .instr_rd_i    (instr_rd),
    .instr_valid_i (instr_valid),
    .halt_req_i    (halt_req),
    .halt_o        (halt)
  );

  // Output register takes a new item when empty or when the current one is leaving.
  assign load_d = !valid_q || dump_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      cyc_q   <= '0;
      valid_q <= 1'b0;
      kind_q  <= DK_MEM;
      index_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // the halt cycle itself is counted, then the count freezes
          if (cyc_q != CYC_MAX) cyc_q <= cyc_q + CYC_W'(1);
          if (halt) begin
            state_q <= ST_MEM;
            idx_q   <= '0;
          end
        end
        ST_MEM: begin
          if (load_d) begin
            valid_q <= 1'b1;
            kind_q  <= DK_MEM;
            index_q <= idx_q;
            data_q  <= mem_rd;
            if (idx_q == MEM_LAST) begin
              idx_q   <= '0;
              state_q <= ST_REG;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_REG: begin
          if (load_d) begin
            valid_q <= 1'b1;
            kind_q  <= DK_REG;
            index_q <= idx_q;
            data_q  <= reg_rd;
            if (idx_q == REG_LAST) begin
              idx_q   <= '0;
              state_q <= ST_END;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_END: begin
          if (load_d) begin
            valid_q <= 1'b1;
            kind_q  <= DK_END;
            index_q <= '0;
            data_q  <= DATA_W'(cyc_q);
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // end marker is the last item; done follows its handshake
          if (valid_q && dump_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign cpu_stall  = !run_st;
  assign mem_a      = (state_q == ST_MEM) ? idx_q : '0;
  assign reg_a      = (state_q == ST_REG) ? idx_q : '0;
  assign dump_valid = valid_q;
  assign dump_kind  = kind_q;
  assign dump_index = index_q;
  assign dump_data  = data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_state_dump_controller.sv
// Randomised scoreboard bench for state_dump_controller with small memory/register sizes.
// Stimulus drives fetches and ready; expected stream items are queued at the predicted halt.
// A negedge monitor pops and compares every accepted item and checks stability under backpressure.
module tb_state_dump_controller;
  import state_dump_controller_pkg::*;

  localparam int DATA_W       = 32;
  localparam int MEM_DEPTH    = 8;
  localparam int REG_COUNT    = 4;
  localparam int HALT_CONFIRM = 3;
  localparam int CYC_W        = 6;
  localparam int IDX_W        = 3;
  localparam int N_ITEMS      = MEM_DEPTH + REG_COUNT + 1;
  localparam int CYC_MAX      = (1 << CYC_W) - 1;
  localparam logic [7:0] T2_VALID = 8'b1010_1111;  // bit i = instr_valid of fetch i
  localparam logic [6:0] T2_READY = 7'b100_1111;   // bit i = dump_ready of cycle i

  typedef struct packed {
    logic [1:0]        kind;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] instr_rd;
  logic              instr_valid;
  logic              halt_req;
  logic              cpu_stall;
  logic [IDX_W-1:0]  mem_a;
  logic [DATA_W-1:0] mem_rd;
  logic [IDX_W-1:0]  reg_a;
  logic [DATA_W-1:0] reg_rd;
  logic              dump_valid;
  logic              dump_ready;
  logic [1:0]        dump_kind;
  logic [IDX_W-1:0]  dump_index;
  logic [DATA_W-1:0] dump_data;
  logic              done;

  logic [DATA_W-1:0] mem_arr [1 << IDX_W];
  logic [DATA_W-1:0] reg_arr [1 << IDX_W];

  item_t exp_q[$];
  bit    rdy_pat[$];
  int    ready_mode;
  int    n_chk = 0;
  int    n_fail = 0;
  int    m_cyc;
  int    m_conf;

  always #5 clk = ~clk;

  assign mem_rd = mem_arr[mem_a];
  assign reg_rd = reg_arr[reg_a];

  state_dump_controller #(
    .DATA_W       (DATA_W),
    .MEM_DEPTH    (MEM_DEPTH),
    .REG_COUNT    (REG_COUNT),
    .HALT_WORD    (32'h0000_0000),
    .HALT_CONFIRM (HALT_CONFIRM),
    .CYC_W        (CYC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_rd    (instr_rd),
    .instr_valid (instr_valid),
    .halt_req    (halt_req),
    .cpu_stall   (cpu_stall),
    .mem_a       (mem_a),
    .mem_rd      (mem_rd),
    .reg_a       (reg_a),
    .reg_rd      (reg_rd),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_kind   (dump_kind),
    .dump_index  (dump_index),
    .dump_data   (dump_data),
    .done        (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {cpu_stall, dump_valid, dump_kind, dump_index, dump_data, done, mem_a, reg_a}, 64'd0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < (1 << IDX_W); i++) begin
      mem_arr[i] = $urandom;
      reg_arr[i] = $urandom;
    end
  endtask

  // Whole dump is known the moment halt is decided: memory, registers, cycle count.
  task automatic push_expected();
    for (int i = 0; i < MEM_DEPTH; i++) exp_q.push_back({DK_MEM, IDX_W'(i), mem_arr[i]});
    for (int i = 0; i < REG_COUNT; i++) exp_q.push_back({DK_REG, IDX_W'(i), reg_arr[i]});
    exp_q.push_back({DK_END, IDX_W'(0), DATA_W'(m_cyc)});
  endtask

  // One RUN cycle: drive a fetch/request, advance the reference model, check after the edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] w, input bit hr, output bit halted);
    instr_valid = v;
    instr_rd    = w;
    halt_req    = hr;
    if (m_cyc < CYC_MAX) m_cyc++;
    halted = 1'b0;
    if (hr) begin
      halted = 1'b1;
    end else if (v) begin
      if (w == '0) begin
        m_conf++;
        halted = (m_conf == HALT_CONFIRM);
      end else begin
        m_conf = 0;
      end
    end
    if (halted) push_expected();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    halt_req    = 1'b0;
    instr_rd    = $urandom;
    if (halted) begin
      chk("stall_after_halt", {cpu_stall, dump_valid, done, mem_a, reg_a}, {1'b1, 2'b00, 6'd0});
      m_conf = 0;
    end else begin
      chk("run_outputs", {cpu_stall, dump_valid, done, mem_a, reg_a}, 9'd0);
    end
  endtask

  // Called just after the halt edge; waits (bounded) for done.
  task automatic finish_dump(input int exp_cycles);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("first_item_latency", dump_valid, 1'b1);
    end
    chk("done_seen", done, 1'b1);
    if (exp_cycles >= 0) chk("dump_cycles", n, exp_cycles);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    rdy_pat.delete();
    m_cyc  = 0;
    m_conf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ready driver
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ($urandom_range(0, 2) != 0);
        default: dump_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    item_t e;
    item_t held;
    bit    hold_vld;
    bit    done_chk;
    hold_vld = 1'b0;
    done_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_vld = 1'b0;
        done_chk = 1'b0;
      end else begin
        if (done_chk) begin
          chk("done_after_end", {done, dump_valid}, 2'b10);
          done_chk = 1'b0;
        end
        if (hold_vld)
          chk("hold_stable", {dump_valid, dump_kind, dump_index, dump_data}, {1'b1, held});
        hold_vld = 1'b0;
        if (dump_valid) begin
          if (dump_ready) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_item: got kind %0d index %0d data 0x%0h, expected no item",
                       dump_kind, dump_index, dump_data);
            end else begin
              e = exp_q.pop_front();
              chk("item", {dump_kind, dump_index, dump_data}, e);
              if (e.kind == DK_END) done_chk = 1'b1;
            end
          end else begin
            hold_vld = 1'b1;
            held     = {dump_kind, dump_index, dump_data};
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    int hpos;
    bit v;
    logic [DATA_W-1:0] w;
    bit hr;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_rd    = '0;
    halt_req    = 1'b0;
    ready_mode  = 0;
    m_cyc       = 0;
    m_conf      = 0;
    fill_mem();
    #12;
    chk_reset_vals("reset_values");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // five ordinary fetches then three halt words; ready held high
    hpos = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 5) ? DATA_W'(i * 4 + 4) : '0, 1'b0, h);
      if (h) begin hpos = i; break; end
    end
    chk("halt_pos_plain", hpos, 7);
    finish_dump(N_ITEMS + 1);

    // halt request after completion changes nothing
    halt_req = 1'b1; instr_valid = 1'b1; instr_rd = '0;
    @(posedge clk); #1;
    halt_req = 1'b0; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_ignores_halt", {cpu_stall, done, dump_valid}, 3'b110);

    // 0,0,X,0,gap,0,gap,0: X clears, gaps hold; ready pattern stalls item 2 for two cycles
    do_reset();
    fill_mem();
    ready_mode = 2;
    hpos = -1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) for (int j = 0; j < 7; j++) rdy_pat.push_back(T2_READY[j]);
      w = (i == 2) ? 32'h0000_1234 : (i == 6) ? 32'h0000_dead : '0;
      step(T2_VALID[i], w, 1'b0, h);
      if (h) begin hpos = i; break; end
    end
    chk("halt_pos_gaps", hpos, 7);
    finish_dump(N_ITEMS + 3);

    // halt request on top of a partial confirm count
    do_reset();
    fill_mem();
    ready_mode = 1;
    hpos = -1;
    for (int i = 0; i < 3; i++) begin
      step(i < 2, '0, i == 2, h);
      if (h) begin hpos = i; break; end
    end
    chk("halt_pos_req", hpos, 2);
    finish_dump(-1);

    // random programs and random backpressure
    for (int r = 0; r < 6; r++) begin
      do_reset();
      fill_mem();
      ready_mode = $urandom_range(0, 1);
      for (int i = 0; i < 200; i++) begin
        v  = ($urandom_range(0, 3) != 0);
        w  = ($urandom_range(0, 2) == 0) ? '0 : ($urandom | 32'h1);
        hr = ($urandom_range(0, 39) == 0) || (i == 199);
        step(v, w, hr, h);
        if (h) break;
      end
      finish_dump((ready_mode == 0) ? N_ITEMS + 1 : -1);
    end

    // cycle counter saturation
    do_reset();
    fill_mem();
    ready_mode = 1;
    hpos = -1;
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 32'h0000_0021, i == 69, h);
      if (h) begin hpos = i; break; end
    end
    chk("halt_pos_sat", hpos, 69);
    finish_dump(-1);

    // reset in the middle of the register walk, then a fresh dump
    do_reset();
    fill_mem();
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, '0, 1'b0, h);
      if (h) break;
    end
    repeat (1 + MEM_DEPTH + 2) @(posedge clk);
    #1;
    chk("pre_reset_item", {dump_valid, dump_kind, dump_index, dump_data}, {1'b1, DK_REG, 3'd2, reg_arr[2]});
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset_values");
    do_reset();
    fill_mem();
    ready_mode = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, '0, 1'b0, h);
      if (h) break;
    end
    chk("halt_after_reset", h, 1'b1);
    finish_dump(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/state_dump_controller.md
# state_dump_controller

Synthesizable end-of-program halt detector and architectural-state streamer for the MIPS CPU test system. It watches the instruction fetch bus and declares halt on a configurable halt word or an external request. It then freezes the CPU and walks data memory followed by the register file. Every word leaves on a valid/ready stream, followed by an end marker that carries the run's cycle count, so hardware runs produce the same memory/register dump the simulation flow prints.

## Interface
Parameters:
- DATA_W, 32, word width of instruction, memory, register and dump data
- MEM_DEPTH, 64, data memory words to dump (≥2)
- REG_COUNT, 32, registers to dump (≥2)
- HALT_WORD, 32'h0000_0000, instruction value that signals halt
- HALT_CONFIRM, 1, consecutive valid fetches of HALT_WORD required (≥1)
- CYC_W, 32, cycle counter width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- instr_rd  in  DATA_W  fetched instruction
- instr_valid  in  1  instr_rd is a real fetch this cycle
- halt_req  in  1  external halt, single-cycle pulse sufficient
- cpu_stall  out  1  freezes PC and inhibits CPU memory/register writes
- mem_a  out  IDX_W  data memory word address (combinational-read memory)
- mem_rd  in  DATA_W  memory read data, same cycle as mem_a
- reg_a  out  IDX_W  register file read address (combinational read)
- reg_rd  in  DATA_W  register read data, same cycle as reg_a
- dump_valid  out  1  stream item present
- dump_ready  in  1  sink accepts item
- dump_kind  out  2  0 = memory, 1 = register, 2 = end marker
- dump_index  out  IDX_W  word/register index (0 for end marker)
- dump_data  out  DATA_W  item payload
- done  out  1  dump complete, sticky until reset

IDX_W = max($clog2(MEM_DEPTH), $clog2(REG_COUNT)). mem_a and reg_a are zero-extended to IDX_W.

## Operation
- States: RUN → MEM → REG → END → DONE.
- RUN:
  - cyc_cnt increments each cycle and saturates at all-ones.
  - confirm counter increments on instr_valid && instr_rd==HALT_WORD.
  - It clears on instr_valid with any other word and holds when instr_valid is low.
  - Halt fires when the counter reaches HALT_CONFIRM, or whenever halt_req=1; halt_req has priority.
  - On halt: go to MEM, idx=0, cyc_cnt freezes (the halt cycle is counted).
- Load rule: in MEM/REG/END the output register loads when !dump_valid || dump_ready.
- MEM: mem_a=idx.
  - On load: data=mem_rd, kind=0, index=idx, valid=1, then idx++.
  - After loading idx=MEM_DEPTH-1, go to REG with idx=0.
- REG: reg_a=idx. Same load rule with kind=1. After REG_COUNT-1, go to END.
- END: on load, data=cyc_cnt zero-extended or truncated to DATA_W, kind=2, index=0. Then go to DONE.
- DONE:
  - valid drops when the end marker is accepted.
  - done=1 from the cycle after acceptance; no further items.
  - instr_rd and halt_req are ignored.
- cpu_stall=1 in every state except RUN.
- Outside their dump states, mem_a and reg_a hold 0.
- Reset at any point aborts the dump: state RUN, all counters 0, stream cleared.

## Timing
- Reset values: cpu_stall=0, dump_valid=0, dump_kind=0, dump_index=0, dump_data=0, done=0, mem_a=0, reg_a=0.
- Halt sampled at edge T: cpu_stall high after T. The first item (memory word 0) is valid after edge T+1.
- With dump_ready held high: one item per cycle, MEM_DEPTH+REG_COUNT+1 items back-to-back, no bubbles at MEM→REG or REG→END.
- done rises one edge after the end-marker handshake.
- Backpressure:
  - While dump_valid && !dump_ready, dump_kind, dump_index and dump_data hold stable.
  - The idx, mem_a and reg_a addresses do not advance.
- A halt_req pulse coincident with a partial confirm count halts immediately.
- A halt_req pulse in any non-RUN state has no effect.

## Structure
- Shared package holds:
  - dump_kind encodings DK_MEM, DK_REG, DK_END
  - state enum values
  - the IDX_W computation function
- One natural sub-module, halt_detector: confirm counter plus halt_req merge, emitting a one-cycle halt pulse. The walker FSM and output register stay in state_dump_controller.

## Test plan
- Defaults; program fetches 5 non-zero words then 32'h0 with halt at T → cpu_stall after T; first item mem[0] after T+1; 97 items at one per cycle; end marker data=6; done after that.
- HALT_CONFIRM=3; pattern 0,0,X,0,0,0 (all valid) → halt only on the sixth fetch; instr_valid=0 gaps between zeros neither clear nor count.
- dump_ready toggled 1-0-0-1 during MEM → item at index 2 held unchanged for 2 extra cycles; indices stay contiguous, none skipped or duplicated.
- MEM_DEPTH=4, REG_COUNT=2, memory 10,11,12,13, regs 20,21 → kinds/indices/data: (0,0,10)..(0,3,13),(1,0,20),(1,1,21),(2,0,cycles).
- rst_n low while item reg[7] is valid → all outputs return to reset values asynchronously; after release, a fresh halt replays from mem[0].
- CYC_W=4 with halt after 20 cycles → end marker data=15 (saturated).
